// File: rtl/kim_counter_pkg.sv
// Shared types and defaults for the kim_counter request scheduler.
package kim_counter_pkg;

  localparam int unsigned CNT_DATA_WIDTH_DEF = 7;
  localparam int unsigned REQ_FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StArm,
    StWait
  } sched_state_t;

endpackage

// File: rtl/kim_req_fifo.sv
// Synchronous request FIFO with extra-bit pointers and a registered occupancy count.
module kim_req_fifo #(
  parameter int unsigned Width = 7,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         din,
  output logic [Width-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == FullLvl);
  assign empty   = (level_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_q[AddrW-1:0]];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        level_q <= level_q + 1'b1;
      end else if (do_pop && !do_push) begin
        level_q <= level_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AddrW-1:0]] <= din;
  end

endmodule

// File: rtl/kim_counter_req_sched.sv
// Buffers count targets and issues them one at a time to the counter, waiting for each run.
module kim_counter_req_sched
  import kim_counter_pkg::*;
#(
  parameter int unsigned CNT_DATA_WIDTH = CNT_DATA_WIDTH_DEF,
  parameter int unsigned FIFO_DEPTH     = REQ_FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  input  logic [CNT_DATA_WIDTH-1:0]     req_val,
  output logic                          req_ready,
  input  logic [CNT_DATA_WIDTH-1:0]     cnt,
  output logic                          start,
  output logic [CNT_DATA_WIDTH-1:0]     cnt_val,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  sched_state_t              state_q, state_d;
  logic [CNT_DATA_WIDTH-1:0] target_q, target_d;
  logic [CNT_DATA_WIDTH-1:0] cnt_val_q, cnt_val_d;
  logic                      start_q, start_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      avail_q;
  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [CNT_DATA_WIDTH-1:0] fifo_dout;

  kim_req_fifo #(
    .Width (CNT_DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_valid),
    .pop   (fifo_pop),
    .din   (req_val),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign req_ready = !fifo_full;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    fifo_pop = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // avail_q delays a fresh head by one cycle so a push never bypasses into IDLE.
        if (avail_q && !fifo_empty) begin
          fifo_pop = 1'b1;
          target_d = fifo_dout;
          if (fifo_dout != '0) begin
            state_d = StIssue;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StIssue: state_d = StArm;
      // Counter loads during ARM; a stale cnt equal to target must not end the run.
      StArm:   state_d = StWait;
      StWait: begin
        if (cnt == target_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    start_d   = (state_d == StIssue);
    cnt_val_d = start_d ? target_d : '0;
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      target_q  <= '0;
      cnt_val_q <= '0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      avail_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      cnt_val_q <= cnt_val_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      avail_q   <= !fifo_empty;
    end
  end

  assign start   = start_q;
  assign cnt_val = cnt_val_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_kim_counter_req_sched.sv
// Bench for kim_counter_req_sched: directed table, corner sequences and a random scoreboard run.
module tb_kim_counter_req_sched;

  localparam int W = 7;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_val = '0;
  logic         req_ready;
  logic [W-1:0] cnt;
  logic         start;
  logic [W-1:0] cnt_val;
  logic         busy;
  logic         done;
  logic [2:0]   level;

  kim_counter_req_sched #(
    .CNT_DATA_WIDTH (W),
    .FIFO_DEPTH     (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_val   (req_val),
    .req_ready (req_ready),
    .cnt       (cnt),
    .start     (start),
    .cnt_val   (cnt_val),
    .busy      (busy),
    .done      (done),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Behavioural counter: loads 0 on start, then counts up by one until it reaches its target.
  logic [W-1:0] mcnt, mtgt;
  logic         mrun;
  logic         ovr = 1'b0;
  logic [W-1:0] ovr_val = '0;
  assign cnt = ovr ? ovr_val : mcnt;

  always @(posedge clk) begin
    if (!rst_n) begin
      mcnt <= '0;
      mtgt <= '0;
      mrun <= 1'b0;
    end else if (start) begin
      mcnt <= '0;
      mtgt <= cnt_val;
      mrun <= 1'b1;
    end else if (mrun) begin
      if (mcnt != mtgt) mcnt <= mcnt + 1'b1;
      else mrun <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: accepted targets in order, and whether a counter run is outstanding.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] start_log[$];
  logic [W-1:0] head;
  logic         outst = 1'b0;
  int           n_start = 0;
  int           n_done = 0;
  int           last_start_cyc = 0;
  int           last_start_val = 0;
  int           last_done_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      outst = 1'b0;
    end else begin
      if (start) begin
        n_start++;
        start_log.push_back(cnt_val);
        last_start_cyc = cyc;
        last_start_val = 32'(cnt_val);
        chk("start_while_busy", 32'(outst), 0);
        if (exp_q.size() == 0) begin
          chk("start_unexpected", 1, 0);
        end else begin
          head = exp_q.pop_front();
          chk("start_order", 32'(cnt_val), 32'(head));
        end
        outst = 1'b1;
      end else begin
        chk("cnt_val_idle", 32'(cnt_val), 0);
      end
      if (done) begin
        n_done++;
        last_done_cyc = cyc;
        if (outst) begin
          outst = 1'b0;
        end else if (exp_q.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          head = exp_q.pop_front();
          chk("zero_done_head", 32'(head), 0);
        end
      end
      chk("busy_vs_model", 32'(busy), 32'(outst));
      chk("ready_decode", 32'(req_ready), 32'(level != 3'(D)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cycle(input logic vld, input logic [W-1:0] v);
    logic acc;
    req_valid = vld;
    req_val   = v;
    acc       = vld && req_ready;
    step();
    if (acc) exp_q.push_back(v);
    req_valid = 1'b0;
  endtask

  task automatic run_one(input logic [W-1:0] v, input bit stale, output int s_off,
                         output int s_val, output int ns, output int d_off, output int nd,
                         output int busy_cnt);
    int s0, d0, e, extra;
    s0 = n_start;
    d0 = n_done;
    busy_cnt = 0;
    extra = 0;
    if (stale) begin
      ovr_val = v;
      ovr = 1'b1;
    end
    push_cycle(1'b1, v);
    e = cyc;
    for (int k = 0; k < 400 && extra < 3; k++) begin
      step();
      if (cyc - e >= 4) ovr = 1'b0;
      if (busy) busy_cnt++;
      if (n_done > d0) extra++;
    end
    ovr   = 1'b0;
    ns    = n_start - s0;
    nd    = n_done - d0;
    s_off = last_start_cyc - e;
    s_val = last_start_val;
    d_off = last_done_cyc - e;
  endtask

  typedef struct {
    logic [W-1:0] val;
    int           exp_starts;
    int           exp_done_off;
    bit           stale;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int s_off, s_val, ns, d_off, nd, bc, t, ns0, nd0;
    logic [W-1:0] qexp[5];

    tbl[0] = '{val: 7'd1,   exp_starts: 1, exp_done_off: 5,   stale: 1'b0};
    tbl[1] = '{val: 7'd100, exp_starts: 1, exp_done_off: 104, stale: 1'b0};
    tbl[2] = '{val: 7'd37,  exp_starts: 1, exp_done_off: 41,  stale: 1'b0};
    tbl[3] = '{val: 7'd20,  exp_starts: 1, exp_done_off: 24,  stale: 1'b0};
    tbl[4] = '{val: 7'd20,  exp_starts: 1, exp_done_off: 24,  stale: 1'b1};
    tbl[5] = '{val: 7'd0,   exp_starts: 0, exp_done_off: 2,   stale: 1'b0};
    tbl[6] = '{val: 7'd127, exp_starts: 1, exp_done_off: 131, stale: 1'b0};

    // Reset held with a request pending.
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_val = 7'd55;
    repeat (2) step();
    chk("rst_start", 32'(start), 0);
    chk("rst_cnt_val", 32'(cnt_val), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ready", 32'(req_ready), 1);
    req_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_level", 32'(level), 0);

    foreach (tbl[i]) begin
      run_one(tbl[i].val, tbl[i].stale, s_off, s_val, ns, d_off, nd, bc);
      chk("tbl_start_count", 32'(ns), 32'(tbl[i].exp_starts));
      chk("tbl_done_count", 32'(nd), 1);
      chk("tbl_done_offset", 32'(d_off), 32'(tbl[i].exp_done_off));
      if (tbl[i].exp_starts == 1) begin
        chk("tbl_start_offset", 32'(s_off), 2);
        chk("tbl_start_value", 32'(s_val), 32'(tbl[i].val));
        chk("tbl_busy_cycles", 32'(bc), 32'(tbl[i].exp_done_off - 2));
      end else begin
        chk("tbl_zero_busy", 32'(bc), 0);
      end
      chk("tbl_cnt_val_after", 32'(cnt_val), 0);
      chk("tbl_level_after", 32'(level), 0);
    end

    // Queueing: five back-to-back pushes into a four-deep FIFO.
    qexp = '{7'd5, 7'd3, 7'd7, 7'd2, 7'd9};
    start_log.delete();
    nd0 = n_done;
    foreach (qexp[i]) begin
      chk("queue_ready_before_push", 32'(req_ready), 1);
      push_cycle(1'b1, qexp[i]);
    end
    chk("queue_full_ready", 32'(req_ready), 0);
    chk("queue_full_level", 32'(level), 32'(D));
    t = 0;
    while (n_done - nd0 < 5 && t < 2000) begin
      step();
      t++;
    end
    chk("queue_timeout", 32'(t < 2000), 1);
    chk("queue_start_count", 32'(start_log.size()), 5);
    foreach (qexp[i]) begin
      if (i < start_log.size()) chk("queue_start_seq", 32'(start_log[i]), 32'(qexp[i]));
    end

    // Reset during WAIT with two requests queued.
    push_cycle(1'b1, 7'd60);
    push_cycle(1'b1, 7'd4);
    push_cycle(1'b1, 7'd6);
    repeat (12) step();
    chk("midrst_busy_before", 32'(busy), 1);
    chk("midrst_level_before", 32'(level), 2);
    ns0 = n_start;
    nd0 = n_done;
    rst_n = 1'b0;
    step();
    chk("midrst_done_0", 32'(done), 0);
    step();
    chk("midrst_done_1", 32'(done), 0);
    chk("midrst_level", 32'(level), 0);
    rst_n = 1'b1;
    repeat (30) step();
    chk("midrst_no_start", 32'(n_start - ns0), 0);
    chk("midrst_no_done", 32'(n_done - nd0), 0);
    chk("midrst_busy_after", 32'(busy), 0);
    chk("midrst_level_after", 32'(level), 0);

    // Random traffic checked by the scoreboard.
    for (int i = 0; i < 600; i++) begin
      logic         vld;
      logic [W-1:0] v;
      vld = ($urandom_range(0, 2) == 0);
      v = ($urandom_range(0, 9) == 0) ? 7'd127 : 7'($urandom_range(0, 12));
      push_cycle(vld, v);
    end
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin
      step();
      t++;
    end
    repeat (3) step();
    chk("rand_drain_timeout", 32'(t < 5000), 1);
    chk("rand_queue_empty", 32'(exp_q.size()), 0);
    chk("rand_level_final", 32'(level), 0);
    chk("rand_busy_final", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kim_counter_req_sched.md
# kim_counter_req_sched

Upstream request scheduler for `kim_counter_top`. It accepts count targets on a valid/ready interface and buffers them in a small FIFO. It issues each target to the counter as a one-cycle `start` pulse with `cnt_val`, then watches the counter's `cnt` output until the target is reached. Only then does it issue the next target, so back-to-back requests never restart a counter run in progress.

## Interface
Parameters:
- `CNT_DATA_WIDTH`, 7: width of targets, `cnt_val` and `cnt`; must match the counter.
- `FIFO_DEPTH`, 4: request buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  1  request present.
- `req_val`  in  CNT_DATA_WIDTH  requested count target.
- `req_ready`  out  1  FIFO not full; transfer on `req_valid && req_ready`.
- `cnt`  in  CNT_DATA_WIDTH  live count from `kim_counter_top`.
- `start`  out  1  one-cycle issue pulse to the counter.
- `cnt_val`  out  CNT_DATA_WIDTH  target; equals the issued value while `start`=1, 0 otherwise.
- `busy`  out  1  a counter run is outstanding (ISSUE/ARM/WAIT).
- `done`  out  1  one-cycle pulse when the outstanding run completes.
- `level`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

## Operation
- Reset values: `start`=0, `cnt_val`=0, `busy`=0, `done`=0, `level`=0, `req_ready`=1.
- Reset clears the FIFO pointers and sets the FSM to IDLE. The target register is cleared to 0.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into `target`.
    - If the head is nonzero, go to ISSUE.
    - If the head is 0, pulse `done` next cycle, issue no `start`, and stay IDLE.
  - ISSUE: `start`=1 and `cnt_val`=`target` for exactly this cycle. Next state is ARM.
  - ARM: one cycle in which the counter loads. `cnt` is ignored here so a stale value equal to `target` cannot end the run. Next state is WAIT.
  - WAIT: when `cnt == target`, pulse `done` (registered, next cycle) and go to IDLE. Otherwise stay in WAIT indefinitely.
- `busy`=1 in ISSUE, ARM and WAIT.
- FIFO behaviour:
  - Push on `req_valid && req_ready`; pop only from IDLE.
  - Push and pop in the same cycle are both honoured, and `level` is unchanged.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `req_ready` = `level != FIFO_DEPTH`. When full, `req_ready` is 0 and a push is ignored even if a pop occurs that cycle; the freed slot becomes visible the next cycle.
  - A full FIFO has `level == FIFO_DEPTH`, using the extra pointer bit.
  - A push into an empty FIFO is not bypassed to IDLE in the same cycle.
- Comparison of `cnt` with `target` is exact and unsigned. A value of 2^W−1 is legal.
- Reset asserted mid-run (ARM or WAIT) abandons the run: no `done` pulse, and queued requests are lost. The counter shares `rst_n`.

## Timing
- Idle scheduler with an empty FIFO, request accepted at edge E:
  - FIFO is non-empty after E.
  - IDLE pops at E+1.
  - `start` is high for the cycle E+2..E+3.
  - ARM is E+3..E+4.
  - WAIT starts at E+4.
- `done` rises on the edge after WAIT sees the match, lasts one cycle, and coincides with the return to IDLE.
- Back-to-back runs: a queued request's `start` follows the previous `done` by one cycle, at ≥3 cycles per run plus the counting time.
- Zero target: `done` appears one cycle after the pop. `busy` stays 0.
- All outputs are registered except `req_ready`, which is a combinational decode of `level`.

## Structure
- Shared package `kim_counter_pkg`:
  - `sched_state_t` enum (IDLE, ISSUE, ARM, WAIT).
  - `CNT_DATA_WIDTH_DEF`=7.
  - `REQ_FIFO_DEPTH_DEF`=4.
- Sub-module `kim_req_fifo`: synchronous FIFO with parameters width/depth and ports push/pop/din/dout/full/empty/level, with the same reset.
- The FSM and target register live in `kim_counter_req_sched`.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `req_valid`=1 → all outputs at reset values, `level`=0, no `start`.
- **Single run:** push 100, with the counter model reaching 100 after 100 cycles → exactly one `start` with `cnt_val`=100 at E+2, `busy` high throughout, one `done` pulse, `cnt_val`=0 afterwards.
- **Queueing:** push 5, 3, 7, 2, 9 in consecutive cycles at `FIFO_DEPTH`=4 → `req_ready` drops after 5 entries (one already popped). Starts are issued in order 5, 3, 7, 2, 9, each starting only after the prior `done`.
- **Stale match:** `cnt` already equals 20 when target 20 is issued → no `done` in ARM; `done` comes only after the counter reloads and returns to 20.
- **Zero and max:** push 0 then 127 → `done` for the 0 with no `start`; then `start` with `cnt_val`=127 and completion at `cnt`=127.
- **Reset mid-run:** assert `rst_n`=0 during WAIT with 2 entries queued → no `done`, `level`=0, and no further `start` after release.
